cmd_sequencer: RTL and testbench
================================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL expose parameter ADDR_W, default 10, command RAM address width (1024 entries).
REQ-002 SHALL expose parameter DATA_W, default 16, command word width.
REQ-003 SHALL have ports (name direction width meaning), with one clock and a synchronous, active-high reset:
- dataclk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; enables sequencing
- frame_req  in  1  single-cycle pulse; SPI engine requests next command
- cmd_max_index  in  ADDR_W  last command-list address
- cmd_loop_index  in  ADDR_W  address resumed after cmd_max_index
- cmd_loop_en  in  1  1 = loop the list; 0 = one-shot
- ram_addr  out  ADDR_W  read address to RAM port B (registered)
- ram_data  in  DATA_W  RAM port B read data, valid 1 cycle after ram_addr is sampled
- cmd_word  out  DATA_W  command presented to SPI engine
- cmd_valid  out  1  cmd_word valid
- cmd_ready  in  1  SPI engine accepts cmd_word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of a one-shot list
- overrun  out  1  sticky; frame_req arrived while not IDLE
- loop_count  out  16  completed list wraps (see Configuration)

Function
REQ-004 SHALL implement states IDLE, FETCH, LATCH, PRESENT.
REQ-005 In IDLE with run=1 and frame_req=1: drive ram_addr<=idx and go to FETCH.
REQ-006 In IDLE with run=0: set idx<=0 and ignore frame_req.
REQ-007 On leaving IDLE with idx==0: capture cmd_max_index, cmd_loop_index and cmd_loop_en into shadow registers; changes mid-list take effect at the next list start.
REQ-008 FETCH: the RAM samples ram_addr; go to LATCH unconditionally.
REQ-009 LATCH: cmd_word<=ram_data, cmd_valid<=1; go to PRESENT. Latency is frame_req to cmd_valid = 3 cycles.
REQ-010 PRESENT: hold cmd_word and cmd_valid stable until cmd_ready=1. On acceptance, cmd_valid<=0, advance idx, go to IDLE.
REQ-011 Advance rule, when idx != shadow max: idx+1.
REQ-012 Advance rule, when idx == shadow max and loop_en=1: idx<=shadow loop index (0 if loop index > max); loop_count+1.
REQ-013 Advance rule, when idx == shadow max and loop_en=0: idx<=0; done pulses for 1 cycle.
REQ-014 loop_count SHALL wrap from 16'hFFFF to 0.
REQ-015 run deasserted outside IDLE SHALL NOT abort the transaction; it completes the current handshake, then REQ-006 applies.
REQ-016 frame_req while busy=1 SHALL set overrun=1, is otherwise ignored, and is not queued; overrun clears only on reset.
REQ-017 cmd_ready while cmd_valid=0 SHALL be ignored.
REQ-018 Max index 0 SHALL repeat address 0 every frame.
REQ-019 The block SHALL never drive a write to the RAM.

Reset
REQ-020 On reset=1 at a clock edge: state=IDLE, idx=0, ram_addr=0, cmd_word=0, cmd_valid=0, done=0, overrun=0, loop_count=0, shadow registers=0.
REQ-021 Reset mid-handshake SHALL drop cmd_valid on the next cycle with no acceptance or advance.

Configuration
REQ-022 Macro CMD_SEQ_LOOP_COUNT_EN defined: loop_count counter is implemented per REQ-012/REQ-014.
REQ-023 Macro CMD_SEQ_LOOP_COUNT_EN undefined: no counter register; loop_count tied to 16'h0000; all other behaviour unchanged.

Verification
REQ-024 RAM[0..3]=16'hA000..A003, max=3, loop_en=0, four frame_req each followed by a 1-cycle cmd_ready -> cmd_word A000, A001, A002, A003; done pulses once after the 4th accept; idx=0.
REQ-025 max=3, loop=1, loop_en=1, six frames -> sequence A000, A001, A002, A003, A001, A002; loop_count=1 (0 when macro undefined).
REQ-026 frame_req, hold cmd_ready=0 for 10 cycles, second frame_req during PRESENT -> cmd_word stable for 10 cycles; overrun=1; no extra fetch.
REQ-027 Change cmd_max_index from 3 to 1 after the 2nd frame -> list still runs to 3; the next list wraps at 1.
REQ-028 Assert reset while in PRESENT -> next cycle cmd_valid=0, idx=0, overrun=0; next frame returns RAM[0].
REQ-029 max=2, loop=5, loop_en=1 -> after index 2 the list wraps to 0.

Source files
------------

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: on each frame request, reads one command word from a
// command RAM and hands it to the SPI engine through a valid/ready handshake.
// The read index walks the list and then either wraps to a loop point or
// ends the list with a done pulse.
// Optional feature: define CMD_SEQ_LOOP_COUNT_EN to implement the 16-bit
// completed-wrap counter on loop_count. Without it, loop_count reads zero.
module cmd_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              dataclk,
    input  logic              reset,
    input  logic              run,
    input  logic              frame_req,
    input  logic [ADDR_W-1:0] cmd_max_index,
    input  logic [ADDR_W-1:0] cmd_loop_index,
    input  logic              cmd_loop_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] cmd_word,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [15:0]       loop_count
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, PRESENT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] loop_idx_q, loop_idx_d;
    logic              loop_en_q, loop_en_d;
    logic [DATA_W-1:0] cmd_word_q, cmd_word_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
`ifdef CMD_SEQ_LOOP_COUNT_EN
    logic [15:0]       loop_count_q, loop_count_d;
`endif

    // Next-state, list advance and output computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ram_addr_d  = ram_addr_q;
        max_d       = max_q;
        loop_idx_d  = loop_idx_q;
        loop_en_d   = loop_en_q;
        cmd_word_d  = cmd_word_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 1'b0;
        // A request that arrives mid-transaction is dropped, but remembered.
        overrun_d   = overrun_q | (frame_req && (state_q != IDLE));
`ifdef CMD_SEQ_LOOP_COUNT_EN
        loop_count_d = loop_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (!run) begin
                    idx_d = '0;
                end else if (frame_req) begin
                    ram_addr_d = idx_q;
                    state_d    = FETCH;
                    // List configuration is frozen for the whole list so
                    // software can reprogram it while a list is running.
                    if (idx_q == '0) begin
                        max_d      = cmd_max_index;
                        loop_idx_d = cmd_loop_index;
                        loop_en_d  = cmd_loop_en;
                    end
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                cmd_word_d  = ram_data;
                cmd_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (idx_q != max_q) begin
                        idx_d = idx_q + ADDR_W'(1);
                    end else if (loop_en_q) begin
                        // A loop point beyond the list end restarts the list.
                        idx_d = (loop_idx_q > max_q) ? '0 : loop_idx_q;
`ifdef CMD_SEQ_LOOP_COUNT_EN
                        loop_count_d = loop_count_q + 16'd1;
`endif
                    end else begin
                        idx_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ram_addr_q  <= '0;
            max_q       <= '0;
            loop_idx_q  <= '0;
            loop_en_q   <= 1'b0;
            cmd_word_q  <= '0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ram_addr_q  <= ram_addr_d;
            max_q       <= max_d;
            loop_idx_q  <= loop_idx_d;
            loop_en_q   <= loop_en_d;
            cmd_word_q  <= cmd_word_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef CMD_SEQ_LOOP_COUNT_EN
    // Completed-wrap counter, free-running modulo 2^16
    always_ff @(posedge dataclk) begin
        if (reset) begin
            loop_count_q <= 16'h0000;
        end else begin
            loop_count_q <= loop_count_d;
        end
    end

    assign loop_count = loop_count_q;
`else
    assign loop_count = 16'h0000;
`endif

    assign ram_addr  = ram_addr_q;
    assign cmd_word  = cmd_word_q;
    assign cmd_valid = cmd_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Testbench for cmd_sequencer: directed vector table, hand-written
// handshake/reset corner cases, and randomized frames against a list model.
module tb_cmd_sequencer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
`ifdef CMD_SEQ_LOOP_COUNT_EN
    localparam int LC_EN = 1;
`else
    localparam int LC_EN = 0;
`endif

    logic              dataclk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              frame_req = 1'b0;
    logic [ADDR_W-1:0] cmd_max_index = '0;
    logic [ADDR_W-1:0] cmd_loop_index = '0;
    logic              cmd_loop_en = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data = '0;
    logic [DATA_W-1:0] cmd_word;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [15:0]       loop_count;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_pass  = 0;
    int n_total = 0;

    cmd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .dataclk(dataclk), .reset(reset), .run(run), .frame_req(frame_req),
        .cmd_max_index(cmd_max_index), .cmd_loop_index(cmd_loop_index),
        .cmd_loop_en(cmd_loop_en), .ram_addr(ram_addr), .ram_data(ram_data),
        .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .overrun(overrun), .loop_count(loop_count)
    );

    always #5 dataclk = ~dataclk;

    // Synchronous-read RAM port B
    always @(posedge dataclk) ram_data <= mem[ram_addr];

    task automatic step();
        @(posedge dataclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Request one command, hold it for `hold` cycles, accept it.
    task automatic frame(input int hold, output logic [15:0] word);
        int n;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        chk("done_low", 32'(done), 0);
        n = 1;
        while (!cmd_valid && n < 8) begin
            step();
            n++;
        end
        chk("latency", n, 3);
        word = cmd_word;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_word", 32'(cmd_word), 32'(word));
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("valid_drop", 32'(cmd_valid), 0);
    endtask

    // List model: current index, frozen list config, wrap count
    int m_idx, m_max, m_li, m_lc;
    bit m_en;

    function automatic void m_reset();
        m_idx = 0; m_max = 0; m_li = 0; m_en = 0; m_lc = 0;
    endfunction

    function automatic void m_start(int mx, int li, bit en);
        if (m_idx == 0) begin
            m_max = mx; m_li = li; m_en = en;
        end
    endfunction

    function automatic bit m_accept();
        if (m_idx < m_max) begin
            m_idx = m_idx + 1;
            return 1'b0;
        end
        if (m_en) begin
            m_idx = (m_li > m_max) ? 0 : m_li;
            m_lc = (m_lc + 1) % 65536;
            return 1'b0;
        end
        m_idx = 0;
        return 1'b1;
    endfunction

    typedef struct {
        bit rst;
        int mx;
        int li;
        bit en;
        int hold;
        int exp_word;
        bit exp_done;
        int exp_lc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [15:0] w;
        bit          ed;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'(16'hA000 + i);

        // basic one-shot list of four, then back to index 0
        tbl.push_back('{1, 3, 0, 0, 1, 16'hA000, 0, 0});
        tbl.push_back('{0, 3, 0, 0, 0, 16'hA001, 0, 0});
        tbl.push_back('{0, 3, 0, 0, 2, 16'hA002, 0, 0});
        tbl.push_back('{0, 3, 0, 0, 0, 16'hA003, 1, 0});
        tbl.push_back('{0, 3, 0, 0, 0, 16'hA000, 0, 0});
        // looping list resuming at 1
        tbl.push_back('{1, 3, 1, 1, 0, 16'hA000, 0, 0});
        tbl.push_back('{0, 3, 1, 1, 1, 16'hA001, 0, 0});
        tbl.push_back('{0, 3, 1, 1, 0, 16'hA002, 0, 0});
        tbl.push_back('{0, 3, 1, 1, 0, 16'hA003, 0, 1});
        tbl.push_back('{0, 3, 1, 1, 3, 16'hA001, 0, 1});
        tbl.push_back('{0, 3, 1, 1, 0, 16'hA002, 0, 1});
        // max changed mid-list takes effect at the next list
        tbl.push_back('{1, 3, 0, 1, 0, 16'hA000, 0, 0});
        tbl.push_back('{0, 3, 0, 1, 0, 16'hA001, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 16'hA002, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 16'hA003, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 0, 16'hA000, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 0, 16'hA001, 0, 2});
        tbl.push_back('{0, 1, 0, 1, 0, 16'hA000, 0, 2});
        // loop index beyond max restarts at 0
        tbl.push_back('{1, 2, 5, 1, 0, 16'hA000, 0, 0});
        tbl.push_back('{0, 2, 5, 1, 0, 16'hA001, 0, 0});
        tbl.push_back('{0, 2, 5, 1, 0, 16'hA002, 0, 1});
        tbl.push_back('{0, 2, 5, 1, 0, 16'hA000, 0, 1});
        // max index 0 repeats address 0
        tbl.push_back('{1, 0, 0, 1, 0, 16'hA000, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 16'hA000, 0, 2});
        tbl.push_back('{0, 0, 0, 0, 0, 16'hA000, 1, 2});
        tbl.push_back('{0, 0, 0, 0, 1, 16'hA000, 1, 2});

        // reset state
        run = 1'b1;
        do_reset();
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_loop_count", 32'(loop_count), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_cmd_word", 32'(cmd_word), 0);

        // vector table
        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            cmd_max_index  = ADDR_W'(tbl[k].mx);
            cmd_loop_index = ADDR_W'(tbl[k].li);
            cmd_loop_en    = tbl[k].en;
            frame(tbl[k].hold, w);
            chk("tbl_word", 32'(w), 32'(tbl[k].exp_word));
            chk("tbl_done", 32'(done), 32'(tbl[k].exp_done));
            chk("tbl_loop_count", 32'(loop_count), 32'(tbl[k].exp_lc * LC_EN));
            chk("tbl_overrun", 32'(overrun), 0);
        end

        // stall in PRESENT with a dropped second request
        do_reset();
        cmd_max_index = 10'd3; cmd_loop_en = 1'b0; cmd_loop_index = '0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        step();
        chk("stall_valid", 32'(cmd_valid), 1);
        for (int i = 0; i < 10; i++) begin
            frame_req = (i == 3);
            step();
            chk("stall_word", 32'(cmd_word), 32'h0000A000);
            chk("stall_addr", 32'(ram_addr), 0);
        end
        frame_req = 1'b0;
        chk("stall_overrun", 32'(overrun), 1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_queue_busy", 32'(busy), 0);
        end
        frame(0, w);
        chk("after_stall_word", 32'(w), 32'h0000A001);
        chk("overrun_sticky", 32'(overrun), 1);

        // reset during PRESENT, with cmd_ready offered on the same edge
        do_reset();
        frame(0, w);
        chk("pre_rst_word", 32'(w), 32'h0000A000);
        frame_req = 1'b1;
        step();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        chk("pre_rst_overrun", 32'(overrun), 1);
        chk("pre_rst_present", 32'(cmd_word), 32'h0000A001);
        reset = 1'b1;
        cmd_ready = 1'b1;
        step();
        reset = 1'b0;
        cmd_ready = 1'b0;
        chk("mid_rst_valid", 32'(cmd_valid), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        frame(0, w);
        chk("post_rst_word", 32'(w), 32'h0000A000);

        // run dropped mid-transaction completes, then rewinds the list
        do_reset();
        frame(0, w);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        run = 1'b0;
        step();
        step();
        chk("run_drop_valid", 32'(cmd_valid), 1);
        chk("run_drop_word", 32'(cmd_word), 32'h0000A001);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("run_low_ignore", 32'(busy), 0);
        end
        run = 1'b1;
        frame(0, w);
        chk("run_rewind_word", 32'(w), 32'h0000A000);

        // cmd_ready while idle is ignored
        cmd_ready = 1'b1;
        step();
        step();
        cmd_ready = 1'b0;
        frame(0, w);
        chk("idle_ready_word", 32'(w), 32'h0000A001);

        // randomized frames against the list model
        do_reset();
        m_reset();
        for (int k = 0; k < 60; k++) begin
            int mx, li;
            bit en;
            if ($urandom_range(0, 7) == 0) begin
                run = 1'b0;
                repeat ($urandom_range(1, 2)) step();
                run = 1'b1;
                m_idx = 0;
            end
            mx = $urandom_range(0, 5);
            li = $urandom_range(0, 7);
            en = 1'($urandom_range(0, 1));
            cmd_max_index  = ADDR_W'(mx);
            cmd_loop_index = ADDR_W'(li);
            cmd_loop_en    = en;
            m_start(mx, li, en);
            frame($urandom_range(0, 3), w);
            chk("rnd_word", 32'(w), 32'(16'hA000 + m_idx));
            ed = m_accept();
            chk("rnd_done", 32'(done), 32'(ed));
            chk("rnd_loop_count", 32'(loop_count), 32'(m_lc * LC_EN));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
